mult_share_sched: RTL and testbench

Round-robin scheduler that time-shares one fixed-point multiplier among NUM_REQ requesters in the SPGD datapath (gradient, perturbation and gain-update paths). It accepts operand pairs over valid/ready handshakes and drives the multiplier's operand inputs from registers. It pipelines the multiplier product through PIPE_STAGES registers and returns each result to its requester with a one-hot response strobe. At most one issue per cycle; sustained throughput is one product per cycle.

---
 rtl/mult_share_sched.sv | 98 +++++++++
 tb/tb_mult_share_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin time-sharing of one multiplier among NUM_REQ requesters,
// with a PIPE_STAGES-deep result pipeline returning tagged products.
module mult_share_sched #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_WIDTH   = DATA_WIDTH,
  parameter int PIPE_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic                          stall_i,
  input  logic                          flush_i,
  output logic [DATA_WIDTH-1:0]         mult_a_o,
  output logic [DATA_WIDTH-1:0]         mult_b_o,
  input  logic [OUT_WIDTH-1:0]          mult_p_i,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [OUT_WIDTH-1:0]          resp_p_o,
  output logic                          busy_o
);
  localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int L  = PIPE_STAGES - 1;

  logic [PW-1:0]         ptr_q, gnt, iss_tag_q;
  logic                  found, accept, iss_v_q, busy_q, busy_d;
  logic [DATA_WIDTH-1:0] mult_a_q, mult_b_q;
  logic                  pv_q [PIPE_STAGES];
  logic [PW-1:0]         pt_q [PIPE_STAGES];
  logic [OUT_WIDTH-1:0]  pd_q [PIPE_STAGES];

  // Descending scan so the candidate closest to ptr overrides the others.
  always_comb begin
    gnt = ptr_q;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
        gnt = PW'((int'(ptr_q) + k) % NUM_REQ);
        found = 1'b1;
      end
  end

  assign accept      = found & ~stall_i & ~flush_i & ~rst;
  assign req_ready_o = accept ? NUM_REQ'(1) << gnt : '0;

  always_comb begin
    busy_d = accept | iss_v_q;
    for (int s = 0; s < L; s++) busy_d = busy_d | pv_q[s];
    busy_d = flush_i ? 1'b0 : stall_i ? busy_q : busy_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      iss_v_q   <= 1'b0;
      iss_tag_q <= '0;
      mult_a_q  <= '0;
      mult_b_q  <= '0;
      busy_q    <= 1'b0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        pv_q[s] <= 1'b0;
        pt_q[s] <= '0;
        pd_q[s] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      if (flush_i) begin
        iss_v_q <= 1'b0;
        for (int s = 0; s < PIPE_STAGES; s++) pv_q[s] <= 1'b0;
      end else if (!stall_i) begin
        iss_v_q <= accept;
        if (accept) begin
          mult_a_q  <= req_a_i[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
          mult_b_q  <= req_b_i[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
          iss_tag_q <= gnt;
          ptr_q     <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end
        pv_q[0] <= iss_v_q;
        pt_q[0] <= iss_tag_q;
        pd_q[0] <= mult_p_i;
        for (int s = 1; s < PIPE_STAGES; s++) begin
          pv_q[s] <= pv_q[s-1];
          pt_q[s] <= pt_q[s-1];
          pd_q[s] <= pd_q[s-1];
        end
      end
    end
  end

  // A stalled final-stage entry stays hidden until the stall releases.
  assign resp_valid_o = (pv_q[L] & ~stall_i) ? NUM_REQ'(1) << pt_q[L] : '0;
  assign resp_p_o     = pd_q[L];
  assign mult_a_o     = mult_a_q;
  assign mult_b_o     = mult_b_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: random and directed stimulus against a queue-based model of
// round-robin grants and fixed-latency tagged responses from a 16Q16 multiplier.
module tb_mult_share_sched;
  localparam int N = 4, W = 32, P = 2;

  logic             clk = 1'b0, rst, stall, flush, busy;
  logic [N-1:0]     rv, rr, resp_v;
  logic [N*W-1:0]   ra, rb;
  logic [W-1:0]     ma, mb, mp, resp_p;
  logic signed [63:0] full;

  typedef struct {
    int         tag;
    logic [W-1:0] p;
    int         age;
  } item_t;

  item_t exp_q[$];
  int    mptr = 0;
  int    total = 0;
  int    bad = 0;

  mult_share_sched #(.NUM_REQ(N), .DATA_WIDTH(W), .OUT_WIDTH(W), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst(rst), .req_valid_i(rv), .req_ready_o(rr), .req_a_i(ra), .req_b_i(rb),
    .stall_i(stall), .flush_i(flush), .mult_a_o(ma), .mult_b_o(mb), .mult_p_i(mp),
    .resp_valid_o(resp_v), .resp_p_o(resp_p), .busy_o(busy)
  );

  assign full = $signed(ma) * $signed(mb);
  assign mp   = full[47:16];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] q16(logic [W-1:0] a, logic [W-1:0] b);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return W'(x >>> 16);
  endfunction

  function automatic int pick(int p, logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference model: grants and in-flight ages advance on each clock edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      exp_q.delete();
      mptr = 0;
    end else if (flush) exp_q.delete();
    else if (!stall) begin
      int g;
      foreach (exp_q[i]) exp_q[i].age++;
      g = pick(mptr, rv);
      if (g >= 0) begin
        exp_q.push_back('{g, q16(ra[g*W +: W], rb[g*W +: W]), 0});
        mptr = (g + 1) % N;
      end
    end
  end

  // Monitor: compares handshake, busy and responses mid-cycle.
  initial forever begin
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    g  = pick(mptr, rv);
    er = (g >= 0 && !stall && !flush && !rst) ? N'(1) << g : '0;
    chk("req_ready", 64'(rr), 64'(er));
    chk("busy", 64'(busy), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0 && exp_q[0].age == P && !stall) begin
      chk("resp_valid", 64'(resp_v), 64'(N'(1) << exp_q[0].tag));
      chk("resp_p", 64'(resp_p), 64'(exp_q[0].p));
      void'(exp_q.pop_front());
    end else chk("resp_idle", 64'(resp_v), 64'(0));
  end

  initial begin
    rst = 1'b1; rv = '1; stall = 1'b0; flush = 1'b0;
    rand_ops();
    repeat (3) @(negedge clk);
    chk("rst_mult_a", 64'(ma), 64'(0));
    chk("rst_mult_b", 64'(mb), 64'(0));
    chk("rst_ready", 64'(rr), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_grant", 64'(rr), 64'(4'b0001));
    step();
    rv = '0;
    step();
    ra[2*W +: W] = 32'h0003_0000;
    rb[2*W +: W] = 32'h0002_8000;
    rv = 4'b0100;
    @(negedge clk);
    chk("single_ready", 64'(rr), 64'(4'b0100));
    step();
    rv = '0;
    step();
    step();
    @(negedge clk);
    chk("single_valid", 64'(resp_v), 64'(4'b0100));
    chk("single_p", 64'(resp_p), 64'(32'h0007_8000));
    step();
    rv = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step();
    end
    rv = '0;
    repeat (4) step();
    rv = '1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step();
    end
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    rv = '0;
    repeat (5) step();
    rv = '1;
    rand_ops();
    step();
    rand_ops();
    step();
    rv = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'(0));
    step();
    rv = 4'b1000;
    rand_ops();
    step();
    rv = '0;
    repeat (4) step();
    for (int i = 0; i < 400; i++) begin
      rv = N'($urandom);
      rand_ops();
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    stall = 1'b0;
    flush = 1'b0;
    rv = '1;
    repeat (5) begin
      rand_ops();
      step();
    end
    #3 rst = 1'b1;
    #1;
    chk("async_resp", 64'(resp_v), 64'(0));
    chk("async_ready", 64'(rr), 64'(0));
    chk("async_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("restart_grant", 64'(rr), 64'(4'b0001));
    repeat (6) begin
      rand_ops();
      step();
    end
    rv = '0;
    repeat (6) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
